// File: rtl/apb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_pkg : shared APB phase encoding, address/byte types and helpers
// Rev 1.0
// ----------------------------------------------------------------------------
package apb_pkg;

    localparam int APB_ADDR_WIDTH = 13;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef logic [APB_ADDR_WIDTH-1:0] apb_addr_t;
    typedef logic [7:0]                apb_byte_t;

    function automatic int nbytes(input int w);
        return w / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_byte_mem.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_byte_mem : byte flop array, one big-endian word write port, comb read
// Rev 1.0
// ----------------------------------------------------------------------------
module apb_byte_mem
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_BYTES  = 256,
    parameter int IDX_WIDTH  = $clog2(MEM_BYTES)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [IDX_WIDTH-1:0]  i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int c_nbytes = nbytes(DATA_WIDTH);

    apb_byte_t r_mem [MEM_BYTES];

    // Lane 0 is the most-significant byte and lands at the lowest address.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < c_nbytes; i++) begin
                r_mem[i_addr + IDX_WIDTH'(i)] <= i_wdata[DATA_WIDTH-1-8*i -: 8];
            end
        end
    end

    generate
        for (genvar g = 0; g < c_nbytes; g++) begin : g_rd_lane
            assign o_rdata[DATA_WIDTH-1-8*g -: 8] = r_mem[i_addr + IDX_WIDTH'(g)];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/apb_mem_slave.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_mem_slave : APB slave with byte-addressed memory and fixed wait states
// Rev 1.0
// ----------------------------------------------------------------------------
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 13,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_BYTES   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int                    c_nbytes     = nbytes(DATA_WIDTH);
    localparam int                    c_idx_w      = $clog2(MEM_BYTES);
    localparam logic [3:0]            c_wait       = 4'(WAIT_STATES);
    localparam logic [ADDR_WIDTH-1:0] c_last_addr  = ADDR_WIDTH'(MEM_BYTES - c_nbytes);
    localparam logic [ADDR_WIDTH-1:0] c_align_mask = ADDR_WIDTH'(c_nbytes - 1);

    apb_state_e            r_state;
    apb_state_e            w_state_nxt;
    apb_state_e            w_phase;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic                  w_ready;
    logic                  w_err;
    logic                  w_we;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // SETUP is recognised from the live bus so the following cycle is already ACCESS.
    assign w_phase = (r_state == ACCESS) ? ACCESS : (PSEL ? SETUP : IDLE);

    always_comb begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        case (w_phase)
            SETUP: begin
                if (!PENABLE) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (PSEL && !w_ready) begin
                    w_state_nxt = ACCESS;
                    w_cnt_nxt   = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_ready = (r_state == ACCESS) && (r_cnt == c_wait);
        w_err   = ((PADDR & c_align_mask) != '0) || (PADDR > c_last_addr);
        w_we    = w_ready && PWRITE && !w_err;
        PREADY  = w_ready;
        PSLVERR = w_ready && w_err;
        PRDATA  = (w_ready && !PWRITE && !w_err) ? w_mem_rdata : '0;
    end

    apb_byte_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_BYTES  (MEM_BYTES),
        .IDX_WIDTH  (c_idx_w)
    ) u_mem (
        .clk     (PCLK),
        .i_we    (w_we),
        .i_addr  (PADDR[c_idx_w-1:0]),
        .i_wdata (PWDATA),
        .o_rdata (w_mem_rdata)
    );

endmodule
`default_nettype wire

// File: doc/apb_mem_slave.md
# apb_mem_slave

APB slave with a byte-addressed local memory and programmable wait states. It sits directly downstream of `apb_converter`, on its narrow slave-side bus, and is the synthesizable counterpart of the bench memory model. Data words are big-endian: the byte at the lowest address maps to the most-significant lane. Misaligned or out-of-range accesses complete with `PSLVERR`.

## Interface
- `ADDR_WIDTH`, 13: width of `PADDR`.
- `DATA_WIDTH`, 32: width of `PWDATA`/`PRDATA`. Must be 8, 16, 32 or 64.
- `MEM_BYTES`, 256: memory size in bytes. Must be a multiple of `DATA_WIDTH/8`.
- `WAIT_STATES`, 1: number of `PREADY`-low cycles inserted in each access phase, 0..15.

Ports:
- `PCLK` in 1: clock.
- `PRESETn` in 1: reset, asynchronous, active-low.
- `PSEL` in 1: slave select.
- `PENABLE` in 1: access phase.
- `PWRITE` in 1: 1 = write, 0 = read.
- `PADDR` in `ADDR_WIDTH`: byte address.
- `PWDATA` in `DATA_WIDTH`: write data.
- `PRDATA` out `DATA_WIDTH`: read data. Valid only while `PREADY` is 1; 0 otherwise.
- `PREADY` out 1: transfer complete.
- `PSLVERR` out 1: transfer error. Valid only while `PREADY` is 1; 0 otherwise.

## Operation
- `NBYTES` = `DATA_WIDTH/8`.
- **Byte lanes:** lane i is `[DATA_WIDTH-1-8i -: 8]` and maps to `mem[PADDR+i]`.
- **FSM states:**
  - IDLE: `PSEL`=0.
  - SETUP: `PSEL`=1, `PENABLE`=0.
  - ACCESS: `PSEL`=1, `PENABLE`=1.
- **FSM transitions:**
  - IDLE → SETUP on `PSEL`.
  - SETUP → ACCESS on `PENABLE`.
  - ACCESS → IDLE or SETUP after the `PREADY` cycle, depending on `PSEL` at the next edge.
  - ACCESS → IDLE if `PSEL` drops before `PREADY` (abort).
- **Wait counter (4 bit):**
  - Cleared in IDLE and SETUP.
  - Increments each ACCESS cycle while below `WAIT_STATES`; saturates at `WAIT_STATES`.
- **PREADY:** `PREADY` = ACCESS && (`cnt == WAIT_STATES`). Decoded from the registered state and counter, so no combinational path from `PWDATA`.
- **Error condition:** `err` = (`PADDR % NBYTES != 0`) || (`PADDR > MEM_BYTES - NBYTES`).
- **Write:** on the rising edge that ends the `PREADY` cycle, if `PWRITE` && !`err`, all `NBYTES` bytes commit. Partial writes never occur.
- **Read:** during the `PREADY` cycle, `PRDATA` = concatenation of `mem[PADDR..PADDR+NBYTES-1]`, or 0 if `err`.
- **Erroring access:** `PSLVERR` = `err` in the `PREADY` cycle. Memory is unchanged, and the access takes the same number of wait states as a good access.
- **Abort:** `PSEL` deasserted mid-ACCESS means no write and no `PREADY`.
- **Signal changes mid-access:** `PADDR`/`PWRITE` changes during ACCESS are protocol violations and are not checked. Sampling uses current values.
- **Reset:**
  - State → IDLE, counter → 0.
  - `PREADY`, `PSLVERR`, `PRDATA` → 0.
  - Memory contents are not reset; they are undefined until written.
  - Reset asserted mid-access drops the transfer with no write.

## Timing
- **Zero-wait access:** with `WAIT_STATES`=0, `PREADY`=1 in the first ACCESS cycle. Transfer is 2 cycles (SETUP + ACCESS).
- **General access:** transfer is 2 + `WAIT_STATES` cycles.
- **Write visibility:** a write is visible to a read whose ACCESS begins on the next cycle or later.
- **Back-to-back transfers:** SETUP may immediately follow the `PREADY` cycle. No idle cycle is required.
- **Outputs:** all outputs are combinational decodes of flops plus the current `PADDR` (for `PRDATA`/`PSLVERR`). `PREADY` does not depend on `PADDR`.

## Structure
- **Package `apb_pkg`:**
  - `apb_state_e` (IDLE/SETUP/ACCESS).
  - Function `nbytes(int w)`.
  - Typedefs `apb_addr_t` and `apb_byte_t`.
  - Shared with the converter and the bench.
- **Sub-module `apb_byte_mem`:** flop array of `MEM_BYTES` bytes, one `NBYTES`-wide big-endian write port and a combinational read port.
- **Top level:** FSM, wait counter and error decode.

## Test plan
- **Aligned write then read:** `WAIT_STATES`=0. Write 0x12345678 at 0x04, read 0x04 → `PRDATA`=0x12345678 and `PSLVERR`=0. `mem[4]`=0x12, `mem[7]`=0x78.
- **Wait-state count:** `WAIT_STATES`=3. One write to 0x10 → `PREADY` low for exactly 3 ACCESS cycles, high on the 4th. Transfer totals 5 cycles.
- **Misaligned access:**
  - Write 0xDEADBEEF at 0x06 → `PSLVERR`=1 with `PREADY`; `mem[4..7]` unchanged.
  - Read 0x06 → `PRDATA`=0, `PSLVERR`=1.
- **Out-of-range access:** read at `MEM_BYTES`-0 (0x100) and at 0xFC. Result: 0x100 errors; 0xFC succeeds with the previously written data.
- **Abort:** `WAIT_STATES`=2, write 0xAAAAAAAA at 0x20, drop `PSEL` after 1 ACCESS cycle. A following read of 0x20 returns the old value.
- **Reset mid-access:** assert `PRESETn`=0 asynchronously during a wait cycle. `PREADY`/`PSLVERR`/`PRDATA` go 0 immediately. After release, a read of previously written 0x04 still returns 0x12345678.
